// File: rtl/lcd_shadow_pkg.sv
// Shared constants, fill-state type and cursor helpers for the LCD shadow receiver.
package lcd_shadow_pkg;

    localparam int INSTR_SET_DDRAM = 7;
    localparam int INSTR_SET_CGRAM = 6;
    localparam int INSTR_FUNC_SET  = 5;
    localparam int INSTR_SHIFT     = 4;
    localparam int INSTR_DISP_CTRL = 3;
    localparam int INSTR_ENTRY     = 2;
    localparam int INSTR_HOME      = 1;
    localparam int INSTR_CLEAR     = 0;

    localparam int FUNC_DL_BIT  = 4;
    localparam int SHIFT_SC_BIT = 3;
    localparam int SHIFT_RL_BIT = 2;
    localparam int DISP_D_BIT   = 2;
    localparam int ENTRY_ID_BIT = 1;
    localparam int ENTRY_S_BIT  = 0;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_END  = 7'h27;
    localparam logic [6:0] LINE2_END  = 7'h67;

    localparam int         VISIBLE_COLS = 16;
    localparam int         SHADOW_DEPTH = 32;
    localparam logic [7:0] CHAR_SPACE   = 8'h20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    // DDRAM addresses wrap between the two lines at the controller's line ends.
    function automatic logic [6:0] cursor_step(input logic [6:0] addr, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (addr == LINE1_END)      nxt = LINE2_BASE;
            else if (addr == LINE2_END) nxt = LINE1_BASE;
            else                        nxt = addr + 7'd1;
        end else begin
            if (addr == LINE1_BASE)      nxt = LINE2_END;
            else if (addr == LINE2_BASE) nxt = LINE1_END;
            else                         nxt = addr - 7'd1;
        end
        return nxt;
    endfunction

    function automatic logic addr_mapped(input logic [6:0] addr);
        return ((addr >= LINE1_BASE) && (addr < LINE1_BASE + 7'(VISIBLE_COLS))) ||
               ((addr >= LINE2_BASE) && (addr < LINE2_BASE + 7'(VISIBLE_COLS)));
    endfunction

    // Only meaningful for mapped addresses: bit 6 selects the line.
    function automatic logic [4:0] shadow_index(input logic [6:0] addr);
        return {addr[6], addr[3:0]};
    endfunction

endpackage

// File: rtl/lcd_input_sync.sv
// Two-flop synchronisers for the LCD bus and a registered LCD_EN falling-edge event,
// with RS/RW/DATA captured in the same cycle as the event.
module lcd_input_sync (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_lcd_en,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_rw,
    input  logic [7:0] i_lcd_data,
    output logic       o_event,
    output logic       o_rs,
    output logic       o_rw,
    output logic [7:0] o_data
);

    logic       r_en_s1, r_en_s2, r_en_s3;
    logic       r_rs_s1, r_rs_s2;
    logic       r_rw_s1, r_rw_s2;
    logic [7:0] r_data_s1, r_data_s2;
    logic       r_event, r_rs, r_rw;
    logic [7:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_en_s1   <= 1'b0;
            r_en_s2   <= 1'b0;
            r_en_s3   <= 1'b0;
            r_rs_s1   <= 1'b0;
            r_rs_s2   <= 1'b0;
            r_rw_s1   <= 1'b0;
            r_rw_s2   <= 1'b0;
            r_data_s1 <= 8'h00;
            r_data_s2 <= 8'h00;
            r_event   <= 1'b0;
            r_rs      <= 1'b0;
            r_rw      <= 1'b0;
            r_data    <= 8'h00;
        end else begin
            r_en_s1   <= i_lcd_en;
            r_en_s2   <= r_en_s1;
            r_en_s3   <= r_en_s2;
            r_rs_s1   <= i_lcd_rs;
            r_rs_s2   <= r_rs_s1;
            r_rw_s1   <= i_lcd_rw;
            r_rw_s2   <= r_rw_s1;
            r_data_s1 <= i_lcd_data;
            r_data_s2 <= r_data_s1;
            r_event   <= r_en_s3 & ~r_en_s2;
            r_rs      <= r_rs_s2;
            r_rw      <= r_rw_s2;
            r_data    <= r_data_s2;
        end
    end

    assign o_event = r_event;
    assign o_rs    = r_rs;
    assign o_rw    = r_rw;
    assign o_data  = r_data;

endmodule

// File: rtl/lcd_shadow_receiver.sv
// HD44780 bus snooper keeping a 2x16 shadow of display RAM, cursor and display state.
// Optional sticky error flags are built only when LCD_SHADOW_ERR_EN is defined.
//
// state   | meaning
// ST_IDLE | decoding bus events
// ST_FILL | writing CHAR_SPACE to shadow indices 0..31, bus events dropped
module lcd_shadow_receiver
    import lcd_shadow_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic       LCD_EN,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       init_done,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       char_strobe,
    output logic [2:0] err
);

    logic       w_evt, w_rs, w_rw;
    logic [7:0] w_data;
    logic       w_busy, w_evt_ok, w_wr_char;

    fill_state_t r_state;
    logic [4:0]  r_fill_idx;
    logic [6:0]  r_cursor;
    logic        r_inc, r_disp, r_init, r_cmd_stb, r_char_stb;
    logic [7:0]  r_rd_data;
    logic [7:0]  r_shadow [SHADOW_DEPTH];

    lcd_input_sync u_sync (
        .i_clk      (CLK),
        .i_reset    (reset),
        .i_lcd_en   (LCD_EN),
        .i_lcd_rs   (LCD_RS),
        .i_lcd_rw   (LCD_RW),
        .i_lcd_data (LCD_DATA),
        .o_event    (w_evt),
        .o_rs       (w_rs),
        .o_rw       (w_rw),
        .o_data     (w_data)
    );

    assign w_busy    = (r_state == ST_FILL);
    assign w_evt_ok  = w_evt & ~w_busy;
    assign w_wr_char = w_evt_ok & ~w_rw & w_rs & addr_mapped(r_cursor);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= ST_FILL;
            r_fill_idx <= 5'd0;
            r_cursor   <= LINE1_BASE;
            r_inc      <= 1'b1;
            r_disp     <= 1'b0;
            r_init     <= 1'b0;
            r_cmd_stb  <= 1'b0;
            r_char_stb <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_rd_data  <= r_shadow[rd_addr];
            r_cmd_stb  <= 1'b0;
            r_char_stb <= 1'b0;

            if (r_state == ST_FILL) begin
                r_fill_idx <= r_fill_idx + 5'd1;
                if (r_fill_idx == 5'(SHADOW_DEPTH - 1))
                    r_state <= ST_IDLE;
            end

            if (w_evt_ok && !w_rw) begin
                if (w_rs) begin
                    r_cursor   <= cursor_step(r_cursor, r_inc);
                    r_char_stb <= 1'b1;
                end else if (w_data[INSTR_SET_DDRAM]) begin
                    r_cursor  <= w_data[6:0];
                    r_cmd_stb <= 1'b1;
                end else if (w_data[INSTR_SET_CGRAM]) begin
                    r_cmd_stb <= 1'b0;
                end else if (w_data[INSTR_FUNC_SET]) begin
                    if (w_data[FUNC_DL_BIT])
                        r_init <= 1'b1;
                    r_cmd_stb <= 1'b1;
                end else if (w_data[INSTR_SHIFT]) begin
                    // Display shift (S/C=1) is not modelled; only cursor moves are.
                    if (!w_data[SHIFT_SC_BIT]) begin
                        r_cursor  <= cursor_step(r_cursor, w_data[SHIFT_RL_BIT]);
                        r_cmd_stb <= 1'b1;
                    end
                end else if (w_data[INSTR_DISP_CTRL]) begin
                    r_disp    <= w_data[DISP_D_BIT];
                    r_cmd_stb <= 1'b1;
                end else if (w_data[INSTR_ENTRY]) begin
                    r_inc     <= w_data[ENTRY_ID_BIT];
                    r_cmd_stb <= 1'b1;
                end else if (w_data[INSTR_HOME]) begin
                    r_cursor  <= LINE1_BASE;
                    r_cmd_stb <= 1'b1;
                end else if (w_data[INSTR_CLEAR]) begin
                    r_state    <= ST_FILL;
                    r_fill_idx <= 5'd0;
                    r_cursor   <= LINE1_BASE;
                    r_inc      <= 1'b1;
                    r_cmd_stb  <= 1'b1;
                end
            end
        end
    end

    // Fill and character writes never coincide: events are dropped while filling.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            if (r_state == ST_FILL)
                r_shadow[r_fill_idx] <= CHAR_SPACE;
            else if (w_wr_char)
                r_shadow[shadow_index(r_cursor)] <= w_data;
        end
    end

`ifdef LCD_SHADOW_ERR_EN
    logic       w_unsupported;
    logic [2:0] r_err;

    assign w_unsupported =
        (w_data[7:6] == 2'b01) ||
        ((w_data[7:4] == 4'b0001) && w_data[SHIFT_SC_BIT]) ||
        ((w_data[7:2] == 6'b000001) && w_data[ENTRY_S_BIT]);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_err <= 3'b000;
        end else begin
            if (w_evt && w_busy)
                r_err[2] <= 1'b1;
            if (w_evt_ok && w_rw)
                r_err[1] <= 1'b1;
            if (w_evt_ok && !w_rw && !w_rs && w_unsupported)
                r_err[0] <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 3'b000;
`endif

    assign rd_data     = r_rd_data;
    assign cursor_addr = r_cursor;
    assign display_on  = r_disp;
    assign init_done   = r_init;
    assign busy        = w_busy;
    assign cmd_strobe  = r_cmd_stb;
    assign char_strobe = r_char_stb;

endmodule

// File: tb/tb_lcd_shadow_receiver.sv
// Self-checking bench for lcd_shadow_receiver: bus-level stimulus, shadow model and read scoreboard.
module tb_lcd_shadow_receiver;

    logic       CLK = 1'b0;
    logic       reset;
    logic       LCD_EN, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] cursor_addr;
    logic       display_on, init_done, busy, cmd_strobe, char_strobe;
    logic [2:0] err;

    lcd_shadow_receiver dut (
        .CLK         (CLK),
        .reset       (reset),
        .LCD_EN      (LCD_EN),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_DATA    (LCD_DATA),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cursor_addr (cursor_addr),
        .display_on  (display_on),
        .init_done   (init_done),
        .busy        (busy),
        .cmd_strobe  (cmd_strobe),
        .char_strobe (char_strobe),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] idx;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    bit         rd_issue = 1'b0;
    bit         rd_pend  = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         busy_cnt = 0;
    int         cmd_cnt = 0;
    int         char_cnt = 0;

    logic [7:0] m_mem [32];
    logic [6:0] m_cur;
    logic       m_inc;
    logic [2:0] m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                check_val("rd_queue_empty", 1, 0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check_val($sformatf("rd_data[%0d]", e.idx), rd_data, e.exp);
            end
        end
        rd_pend  = rd_issue;
        rd_issue = 1'b0;
        if (busy)        busy_cnt++;
        if (cmd_strobe)  cmd_cnt++;
        if (char_strobe) char_cnt++;
    end

    function automatic logic [6:0] m_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            case (a)
                7'h27:   return 7'h40;
                7'h67:   return 7'h00;
                default: return a + 7'd1;
            endcase
        end else begin
            case (a)
                7'h00:   return 7'h67;
                7'h40:   return 7'h27;
                default: return a - 7'd1;
            endcase
        end
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_cur = 7'h00;
        m_inc = 1'b1;
    endtask

    task automatic lcd_write(input logic rs, input logic rw, input logic [7:0] d);
        @(posedge CLK); #1;
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_EN = 1'b1;
        repeat (4) @(posedge CLK);
        #1 LCD_EN = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_val("busy_timeout", 1, 0);
    endtask

    task automatic send_cmd(input logic [7:0] d);
        lcd_write(1'b0, 1'b0, d);
        if (d[7])      m_cur = d[6:0];
        else if (d[1] && d[7:2] == 6'b0) m_cur = 7'h00;
        else if (d == 8'h01) begin
            model_clear();
            wait_idle();
        end
        else if (d[7:2] == 6'b000001) m_inc = d[1];
    endtask

    task automatic send_char(input logic [7:0] c);
        lcd_write(1'b1, 1'b0, c);
        if (m_cur <= 7'h0F)                       m_mem[m_cur[3:0]] = c;
        else if (m_cur >= 7'h40 && m_cur <= 7'h4F) m_mem[16 + m_cur[3:0]] = c;
        m_cur = m_step(m_cur, m_inc);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) begin
            rd_exp_t e;
            @(posedge CLK); #1;
            rd_addr = 5'(i);
            e.idx = 5'(i);
            e.exp = m_mem[i];
            rd_q.push_back(e);
            rd_issue = 1'b1;
        end
        repeat (3) @(negedge CLK);
        check_val("rd_queue_drained", rd_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string txt;
        reset = 1'b1; LCD_EN = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
        LCD_DATA = 8'h00; rd_addr = 5'd0;
        m_err = 3'b000;
        model_clear();

        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_busy", busy, 1);
        check_val("rst_rd_data", rd_data, 8'h00);
        check_val("rst_cursor", cursor_addr, 7'h00);
        check_val("rst_display_on", display_on, 0);
        check_val("rst_init_done", init_done, 0);
        check_val("rst_err", err, 3'b000);
        check_val("rst_strobes", {cmd_strobe, char_strobe}, 2'b00);
        reset = 1'b0;
        busy_cnt = 0;
        wait_idle();
        check_val("reset_fill_cycles", busy_cnt, 32);
        read_all();
        check_val("cursor_after_reset", cursor_addr, 7'h00);

        for (int i = 0; i < 4; i++) send_cmd(8'h38);
        send_cmd(8'h08);
        check_val("display_off", display_on, 0);
        send_cmd(8'h01);
        send_cmd(8'h0C);
        send_cmd(8'h06);
        char_cnt = 0;
        txt = "Patient:7";
        for (int i = 0; i < txt.len(); i++) send_char(txt[i]);
        check_val("char_strobes", char_cnt, 9);
        check_val("cursor_line1", cursor_addr, 7'h09);
        check_val("display_on", display_on, 1);
        check_val("init_done", init_done, 1);
        check_val("model_idx8", m_mem[8], 8'h37);
        read_all();

        send_cmd(8'hC0);
        send_char("P");
        send_char("1");
        check_val("cursor_line2", cursor_addr, 7'h42);
        read_all();

        send_cmd(8'hA7);
        check_val("cursor_set_27", cursor_addr, 7'h27);
        send_char("X");
        check_val("cursor_wrap_up", cursor_addr, 7'h40);
        send_cmd(8'h04);
        send_char("Y");
        check_val("cursor_wrap_down", cursor_addr, 7'h27);
        check_val("model_idx16", m_mem[16], 8'h59);
        read_all();

        send_cmd(8'h02);
        check_val("cursor_home", cursor_addr, 7'h00);
        read_all();

        busy_cnt = 0;
        cmd_cnt = 0;
        send_cmd(8'h01);
        check_val("clear_busy_cycles", busy_cnt, 32);
        check_val("clear_cmd_strobes", cmd_cnt, 1);
        check_val("cursor_after_clear", cursor_addr, 7'h00);
        read_all();

        send_char("A");
        char_cnt = 0;
        lcd_write(1'b0, 1'b0, 8'h01);
        check_val("busy_during_fill", busy, 1);
        lcd_write(1'b1, 1'b0, 8'h5A);
        model_clear();
        wait_idle();
        check_val("overrun_no_char_strobe", char_cnt, 0);
        check_val("overrun_cursor", cursor_addr, 7'h00);
`ifdef LCD_SHADOW_ERR_EN
        m_err = 3'b100;
`endif
        check_val("err_overrun", err, m_err);

        lcd_write(1'b1, 1'b1, 8'h41);
        check_val("read_cursor_kept", cursor_addr, 7'h00);
        check_val("read_no_char_strobe", char_cnt, 0);
`ifdef LCD_SHADOW_ERR_EN
        m_err = 3'b110;
`endif
        check_val("err_read", err, m_err);

        send_cmd(8'h40);
`ifdef LCD_SHADOW_ERR_EN
        m_err = 3'b111;
`endif
        check_val("err_cgram", err, m_err);
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
